// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle control FSM for the simplified processor.
// Steps the external PC, latches the fetched instruction into IR and
// decodes it into register-file, data-memory and ALU controls.
module pc_sequencer #(
  parameter int IW  = 12,
  parameter int RAW = 3,
  parameter int DAW = 4,
  parameter int CW  = 8
) (
  input  logic           CLK,
  input  logic           clear,
  input  logic           run,
  input  logic           step,
  input  logic [IW-1:0]  instr_in,
  output logic           pc_enable,
  output logic           pc_increment,
  output logic           ir_load,
  output logic [RAW-1:0] rf_rd_addr_a,
  output logic [RAW-1:0] rf_rd_addr_b,
  output logic           rf_wr_en,
  output logic [RAW-1:0] rf_wr_addr,
  output logic           wb_sel,
  output logic           alu_op,
  output logic [DAW-1:0] dmem_addr,
  output logic           dmem_wr_en,
  output logic           busy,
  output logic           halted,
  output logic [CW-1:0]  retired
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADVANCE = 3'd1,
    S_FETCH   = 3'd2,
    S_DECODE  = 3'd3,
    S_EXEC    = 3'd4,
    S_MEMWB   = 3'd5,
    S_HALTED  = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_STORE = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_HALT  = 3'b111
  } op_t;

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_ir;
  logic            r_step_q;
  logic [CW-1:0]   r_retired;
  logic            w_step_edge;
  logic            w_done;
  logic            w_retire;
  op_t             w_op;
  logic [RAW-1:0]  w_d;
  logic [RAW-1:0]  w_a;
  logic [RAW-1:0]  w_b;
  logic [DAW-1:0]  w_addr;

  assign w_op        = op_t'(r_ir[11:9]);
  assign w_d         = r_ir[8:6];
  assign w_a         = r_ir[5:3];
  assign w_b         = r_ir[2:0];
  assign w_addr      = r_ir[3:0];
  assign w_step_edge = step & ~r_step_q;
  assign retired     = r_retired;

  // State, IR, step history and retired counter; clear dominates everything.
  always_ff @(posedge CLK) begin
    if (clear) begin
      r_state   <= S_IDLE;
      r_ir      <= '0;
      r_step_q  <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state  <= w_next;
      r_step_q <= step;
      if (ir_load) r_ir <= instr_in;
      if (w_retire) r_retired <= r_retired + CW'(1);
    end
  end

  // Next-state and control decode. Instruction completion ("DONE") is not a
  // state: it is folded into the final EXEC/MEMWB cycle via w_done.
  always_comb begin
    w_next       = r_state;
    w_done       = 1'b0;
    w_retire     = 1'b0;
    pc_enable    = 1'b0;
    pc_increment = 1'b0;
    ir_load      = 1'b0;
    rf_rd_addr_a = '0;
    rf_rd_addr_b = '0;
    rf_wr_en     = 1'b0;
    rf_wr_addr   = '0;
    wb_sel       = 1'b0;
    alu_op       = 1'b0;
    dmem_addr    = '0;
    dmem_wr_en   = 1'b0;
    busy         = 1'b0;
    halted       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run || w_step_edge) w_next = S_ADVANCE;
      end
      S_ADVANCE: begin
        busy         = 1'b1;
        pc_enable    = 1'b1;
        pc_increment = 1'b1;
        w_next       = S_FETCH;
      end
      S_FETCH: begin
        busy    = 1'b1;
        ir_load = 1'b1;
        w_next  = S_DECODE;
      end
      S_DECODE: begin
        busy         = 1'b1;
        rf_rd_addr_a = (w_op == OP_STORE) ? w_d : w_a;
        rf_rd_addr_b = w_b;
        w_next       = S_EXEC;
      end
      S_EXEC: begin
        busy         = 1'b1;
        rf_rd_addr_a = (w_op == OP_STORE) ? w_d : w_a;
        rf_rd_addr_b = w_b;
        case (w_op)
          OP_LOAD: begin
            dmem_addr = w_addr;
            w_next    = S_MEMWB;
          end
          OP_STORE: begin
            dmem_addr  = w_addr;
            dmem_wr_en = 1'b1;
            w_done     = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            alu_op     = r_ir[9];
            wb_sel     = 1'b1;
            rf_wr_en   = 1'b1;
            rf_wr_addr = w_d;
            w_done     = 1'b1;
          end
          OP_HALT: begin
            w_retire = 1'b1;
            w_next   = S_HALTED;
          end
          default: w_done = 1'b1;
        endcase
      end
      S_MEMWB: begin
        busy       = 1'b1;
        rf_wr_en   = 1'b1;
        wb_sel     = 1'b0;
        rf_wr_addr = w_d;
        dmem_addr  = w_addr;
        w_done     = 1'b1;
      end
      S_HALTED: begin
        halted = 1'b1;
        w_next = S_HALTED;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_done) begin
      w_retire = 1'b1;
      w_next   = run ? S_ADVANCE : S_IDLE;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: models PC, instruction memory, register file and
// data memory around the sequencer; expected fetches, register writes and
// stores are queued up front and popped as the DUT strobes them.
module tb_pc_sequencer;

  logic       CLK;
  logic       clear, run, step;
  logic [11:0] instr_in;
  logic       pc_enable, pc_increment, ir_load;
  logic [2:0] rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr;
  logic       rf_wr_en, wb_sel, alu_op, dmem_wr_en, busy, halted;
  logic [3:0] dmem_addr;
  logic [7:0] retired;

  pc_sequencer #(.IW(12), .RAW(3), .DAW(4), .CW(8)) dut (
    .CLK(CLK), .clear(clear), .run(run), .step(step), .instr_in(instr_in),
    .pc_enable(pc_enable), .pc_increment(pc_increment), .ir_load(ir_load),
    .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .wb_sel(wb_sel),
    .alu_op(alu_op), .dmem_addr(dmem_addr), .dmem_wr_en(dmem_wr_en),
    .busy(busy), .halted(halted), .retired(retired)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  localparam logic [11:0] NOP = 12'h800;

  // Datapath model
  logic [11:0] imem [8];
  logic [7:0]  rf_init [8];
  logic [7:0]  dmem_init [16];
  logic [7:0]  rf [8];
  logic [7:0]  dmem [16];
  logic [7:0]  dmem_rdata;
  logic [2:0]  pc;
  logic [7:0]  w_alu, w_wdata;

  assign instr_in = imem[pc];
  assign w_alu    = alu_op ? (rf[rf_rd_addr_a] - rf[rf_rd_addr_b])
                           : (rf[rf_rd_addr_a] + rf[rf_rd_addr_b]);
  assign w_wdata  = wb_sel ? w_alu : dmem_rdata;

  always @(posedge CLK) begin
    if (clear) begin
      pc         <= 3'd7;
      dmem_rdata <= '0;
      for (int i = 0; i < 8; i++)  rf[i]   <= rf_init[i];
      for (int i = 0; i < 16; i++) dmem[i] <= dmem_init[i];
    end else begin
      if (pc_enable && pc_increment) pc <= pc + 3'd1;
      dmem_rdata <= dmem[dmem_addr];
      if (rf_wr_en)   rf[rf_wr_addr] <= w_wdata;
      if (dmem_wr_en) dmem[dmem_addr] <= rf[rf_rd_addr_a];
    end
  end

  // Scoreboard and bookkeeping
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] q_pc [$];
  logic [31:0] q_wr [$];
  logic [31:0] q_st [$];
  int unsigned cyc = 0, n_inc = 0, n_wr = 0, n_strobe = 0;
  int unsigned last_inc = 0;
  bit          have_last = 1'b0;
  bit          period_en = 1'b0;
  int unsigned base;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {2'b00, pc_enable, pc_increment, ir_load, rf_rd_addr_a, rf_rd_addr_b,
            rf_wr_en, rf_wr_addr, wb_sel, alu_op, dmem_addr, dmem_wr_en,
            busy, halted, retired};
  endfunction

  // Advance one clock, then sample outputs and service the scoreboard.
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    if (ir_load) begin
      if (q_pc.size() == 0) check_eq("fetch_unexpected", q_pc.size(), 1);
      else check_eq("fetch_pc", {29'd0, pc}, q_pc.pop_front());
    end
    if (rf_wr_en) begin
      n_wr++;
      if (q_wr.size() == 0) check_eq("rf_wr_unexpected", q_wr.size(), 1);
      else check_eq("rf_wr", {21'd0, rf_wr_addr, w_wdata}, q_wr.pop_front());
    end
    if (dmem_wr_en) begin
      if (q_st.size() == 0) check_eq("dmem_wr_unexpected", q_st.size(), 1);
      else check_eq("dmem_wr", {20'd0, dmem_addr, rf[rf_rd_addr_a]}, q_st.pop_front());
    end
    if (pc_enable || ir_load || rf_wr_en || dmem_wr_en) n_strobe++;
    if (!period_en) have_last = 1'b0;
    if (pc_increment) begin
      n_inc++;
      if (period_en && have_last) check_eq("pc_inc_period", cyc - last_inc, 4);
      last_inc  = cyc;
      have_last = 1'b1;
    end
  endtask

  initial begin
    clear = 1'b1; run = 1'b0; step = 1'b0;
    for (int i = 0; i < 8; i++)  begin imem[i] = NOP; rf_init[i] = '0; end
    for (int i = 0; i < 16; i++) dmem_init[i] = '0;
    repeat (3) tick();
    clear = 1'b0;
    tick();
    check_eq("reset_outputs", all_outs(), 0);

    // Single step from reset
    q_pc.push_back(0);
    base = n_inc;
    step = 1'b1;
    tick();
    check_eq("step_c1_pc_inc", pc_increment, 1);
    step = 1'b0;
    tick();
    check_eq("step_c2_ir_load", ir_load, 1);
    check_eq("step_c2_pc_inc", pc_increment, 0);
    repeat (3) tick();
    check_eq("step_retired", retired, 1);
    check_eq("step_busy", busy, 0);
    repeat (20) tick();
    check_eq("step_inc_count", n_inc - base, 1);

    // LOAD r1,[3]; ADD r2,r1,r1; STORE r2,[4]; HALT
    imem[0] = 12'h043; imem[1] = 12'h489; imem[2] = 12'h284; imem[3] = 12'hE00;
    dmem_init[3] = 8'd5;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 4; i++) q_pc.push_back(i);
    q_wr.push_back(32'h105);
    q_wr.push_back(32'h20A);
    q_st.push_back(32'h40A);
    run = 1'b1;
    repeat (17) tick();
    check_eq("prog_not_halted_c17", halted, 0);
    tick();
    check_eq("prog_halted_c18", halted, 1);
    check_eq("prog_retired", retired, 4);
    check_eq("prog_dmem4", dmem[4], 10);
    check_eq("prog_busy_halted", busy, 0);
    base = n_strobe;
    repeat (10) tick();
    check_eq("halted_no_strobes", n_strobe - base, 0);
    check_eq("halted_sticky", halted, 1);

    // Eight NOPs, nine instructions, PC wraps 7->0
    run = 1'b0;
    for (int i = 0; i < 8; i++) imem[i] = NOP;
    dmem_init[3] = '0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("clear_exits_halted", halted, 0);
    for (int i = 0; i < 8; i++) q_pc.push_back(i);
    q_pc.push_back(0);
    base = n_inc;
    period_en = 1'b1;
    run = 1'b1;
    repeat (34) tick();
    run = 1'b0;
    repeat (8) tick();
    period_en = 1'b0;
    check_eq("nop_retired", retired, 9);
    check_eq("nop_inc_count", n_inc - base, 9);
    check_eq("nop_idle", busy, 0);

    // Clear during EXEC of a LOAD
    imem[1] = 12'h043;
    q_pc.push_back(1);
    base = n_wr;
    run = 1'b1;
    repeat (4) tick();
    check_eq("load_exec_dmem_addr", dmem_addr, 3);
    clear = 1'b1; run = 1'b0;
    tick();
    check_eq("clear_mid_load_outputs", all_outs(), 0);
    clear = 1'b0;
    repeat (6) tick();
    check_eq("clear_mid_load_no_wb", n_wr - base, 0);
    imem[1] = NOP;

    // run dropped during DECODE of SUB r3,r1,r2
    imem[0] = 12'h6CA;
    rf_init[1] = 8'd9; rf_init[2] = 8'd4;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    q_pc.push_back(0);
    q_wr.push_back(32'h305);
    run = 1'b1;
    repeat (3) tick();
    check_eq("sub_decode_rd_a", rf_rd_addr_a, 1);
    check_eq("sub_decode_rd_b", rf_rd_addr_b, 2);
    run = 1'b0;
    tick();
    check_eq("sub_exec_alu_op", alu_op, 1);
    check_eq("sub_exec_wr_en", rf_wr_en, 1);
    tick();
    check_eq("sub_then_idle", busy, 0);
    check_eq("sub_retired", retired, 1);
    check_eq("sub_r3", rf[3], 5);

    // step held high for 20 cycles -> one instruction
    q_pc.push_back(1);
    base = n_inc;
    step = 1'b1;
    repeat (20) tick();
    step = 1'b0;
    repeat (3) tick();
    check_eq("held_step_retired", retired, 2);
    check_eq("held_step_inc_count", n_inc - base, 1);

    // run and step together, then a step edge during EXEC
    q_pc.push_back(2);
    base = n_inc;
    run = 1'b1; step = 1'b1;
    tick();
    check_eq("runstep_advance", pc_increment, 1);
    run = 1'b0; step = 1'b0;
    repeat (3) tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (8) tick();
    check_eq("runstep_retired", retired, 3);
    check_eq("runstep_inc_count", n_inc - base, 1);

    check_eq("q_pc_drained", q_pc.size(), 0);
    check_eq("q_wr_drained", q_wr.size(), 0);
    check_eq("q_st_drained", q_st.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
